// File: rtl/turfio_surf_pkg.sv
// turfio_surf_pkg: shared state encoding, default parameters and output decode
package turfio_surf_pkg;
    localparam int DEF_TIMEOUT_CYC = 2**20;
    localparam int DEF_LOCK_CNT    = 16;
    localparam int DEF_HOLDOFF_CYC = 1024;
    localparam int DEF_M1RST_LEN   = 4;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRAIN   = 3'd1,
        ST_CLKON   = 3'd2,
        ST_VALID   = 3'd3,
        ST_M1RST   = 3'd4,
        ST_READY   = 3'd5,
        ST_HOLDOFF = 3'd6
    } state_t;
    typedef struct packed {
        logic train;
        logic rackclk_en;
        logic surf_valid;
        logic mode1rst;
        logic ready;
    } outs_t;
    function automatic outs_t state_outs(state_t s);
        return '{train:      s inside {ST_TRAIN, ST_CLKON, ST_HOLDOFF},
                 rackclk_en: s inside {ST_CLKON, ST_VALID, ST_M1RST, ST_READY},
                 surf_valid: s inside {ST_VALID, ST_M1RST, ST_READY},
                 mode1rst:   s == ST_M1RST,
                 ready:      s == ST_READY};
    endfunction
endpackage

// File: rtl/turfio_surf_lockdet.sv
// turfio_surf_lockdet: saturating run counter of nonzero DOUT words, lock once LOCK_CNT reached
module turfio_surf_lockdet import turfio_surf_pkg::*; #(
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic       sysclk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic [7:0] dout_i,
    output logic       lock_o
);
    localparam int CW = $clog2(LOCK_CNT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (clr_i || dout_i == 8'h00) ? '0 : cnt_q + CW'(cnt_q != CW'(LOCK_CNT));
    end
    always_ff @(posedge sysclk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign lock_o = cnt_q == CW'(LOCK_CNT);
endmodule

// File: rtl/turfio_surf_bringup.sv
// turfio_surf_bringup: SURF link bringup sequencer (train, clock on, lock, mode1reset, ready, retry)
module turfio_surf_bringup import turfio_surf_pkg::*; #(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int M1RST_LEN   = DEF_M1RST_LEN
) (
    input  logic       sysclk_i,
    input  logic       rstn_i,
    input  logic       enable_i,
    input  logic [7:0] dout_i,
    output logic       train_o,
    output logic       rackclk_en_o,
    output logic       surf_valid_o,
    output logic       mode1rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] state_o
);
    localparam int MAX_CYC = (TIMEOUT_CYC > HOLDOFF_CYC)
                             ? ((TIMEOUT_CYC > M1RST_LEN) ? TIMEOUT_CYC : M1RST_LEN)
                             : ((HOLDOFF_CYC > M1RST_LEN) ? HOLDOFF_CYC : M1RST_LEN);
    localparam int TW = $clog2(MAX_CYC) + 1;
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          en_prev_q, fail_q, fail_d, lock;
    outs_t         outs_q;
    turfio_surf_lockdet #(.LOCK_CNT(LOCK_CNT)) u_lockdet (
        .sysclk_i (sysclk_i),
        .rstn_i   (rstn_i),
        .clr_i    (state_q != ST_CLKON),
        .dout_i   (dout_i),
        .lock_o   (lock)
    );
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        state_d = state_q;
        if (!rst_sync_q[1] || !enable_i) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE:    state_d = ST_TRAIN;
                ST_TRAIN:   state_d = ST_CLKON;
                ST_CLKON:   state_d = lock ? ST_VALID : (tmr_q == TW'(TIMEOUT_CYC - 1)) ? ST_HOLDOFF : ST_CLKON;
                ST_VALID:   state_d = ST_M1RST;
                ST_M1RST:   state_d = (tmr_q == TW'(M1RST_LEN - 1)) ? ST_READY : ST_M1RST;
                ST_READY:   state_d = ST_READY;
                ST_HOLDOFF: state_d = (tmr_q == TW'(HOLDOFF_CYC - 1)) ? ST_TRAIN : ST_HOLDOFF;
                default:    state_d = ST_IDLE;
            endcase
        end
        tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(tmr_q != '1);
        fail_d = (enable_i && !en_prev_q) ? 1'b0
               : fail_q || (state_q == ST_CLKON && state_d == ST_HOLDOFF);
    end
    always_ff @(posedge sysclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rst_sync_q <= '0;
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            en_prev_q  <= 1'b0;
            fail_q     <= 1'b0;
            outs_q     <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            en_prev_q  <= enable_i;
            fail_q     <= fail_d;
            outs_q     <= state_outs(state_d);
        end
    end
    assign train_o      = outs_q.train;
    assign rackclk_en_o = outs_q.rackclk_en;
    assign surf_valid_o = outs_q.surf_valid;
    assign mode1rst_o   = outs_q.mode1rst;
    assign ready_o      = outs_q.ready;
    assign fail_o       = fail_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_turfio_surf_bringup.sv
// tb_turfio_surf_bringup: directed checks of bringup, glitch, timeout, disable, reset and lock/timeout race
module tb_turfio_surf_bringup;
    // expected {state, train, rackclk_en, surf_valid, mode1rst, ready}
    localparam logic [7:0] E_IDLE    = {3'd0, 5'b00000};
    localparam logic [7:0] E_TRAIN   = {3'd1, 5'b10000};
    localparam logic [7:0] E_CLKON   = {3'd2, 5'b11000};
    localparam logic [7:0] E_VALID   = {3'd3, 5'b01100};
    localparam logic [7:0] E_M1RST   = {3'd4, 5'b01110};
    localparam logic [7:0] E_READY   = {3'd5, 5'b01101};
    localparam logic [7:0] E_HOLDOFF = {3'd6, 5'b10000};
    logic       sysclk = 1'b0, rstn = 1'b0, en_a = 1'b0, en_b = 1'b0;
    logic [7:0] dout_a = 8'h00, dout_b = 8'h00;
    logic       a_train, a_rck, a_vld, a_m1, a_rdy, a_fail;
    logic       b_train, b_rck, b_vld, b_m1, b_rdy, b_fail;
    logic [2:0] a_st, b_st;
    int         n_cmp = 0, n_bad = 0;
    always #5 sysclk = ~sysclk;
    turfio_surf_bringup #(.TIMEOUT_CYC(1000)) dut_a (
        .sysclk_i(sysclk), .rstn_i(rstn), .enable_i(en_a), .dout_i(dout_a),
        .train_o(a_train), .rackclk_en_o(a_rck), .surf_valid_o(a_vld), .mode1rst_o(a_m1),
        .ready_o(a_rdy), .fail_o(a_fail), .state_o(a_st)
    );
    turfio_surf_bringup #(.TIMEOUT_CYC(17)) dut_b (
        .sysclk_i(sysclk), .rstn_i(rstn), .enable_i(en_b), .dout_i(dout_b),
        .train_o(b_train), .rackclk_en_o(b_rck), .surf_valid_o(b_vld), .mode1rst_o(b_m1),
        .ready_o(b_rdy), .fail_o(b_fail), .state_o(b_st)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic check_a(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, a_st, a_train, a_rck, a_vld, a_m1, a_rdy}, {24'd0, exp});
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask
    initial begin
        #1 check_a("reset_outs", E_IDLE);
        check("reset_fail", a_fail, 0);
        tick(2);
        rstn = 1'b1;
        en_a = 1'b1;
        tick(1); check_a("sync_idle1", E_IDLE);
        tick(1); check_a("sync_idle2", E_IDLE);
        tick(1); check_a("train", E_TRAIN);
        tick(1); check_a("clkon", E_CLKON);
        tick(100);
        dout_a = 8'h5A;
        tick(16); check_a("pre_lock", E_CLKON);
        tick(1);  check_a("valid", E_VALID);
        tick(1);  check_a("m1rst_0", E_M1RST);
        for (int i = 1; i < 4; i++) begin
            tick(1); check_a($sformatf("m1rst_%0d", i), E_M1RST);
        end
        tick(1); check_a("ready", E_READY);
        check("ready_fail", a_fail, 0);
        en_a = 1'b0;
        tick(1); check_a("disable_idle", E_IDLE);
        en_a = 1'b1;
        dout_a = 8'h00;
        tick(2); check_a("glitch_clkon", E_CLKON);
        dout_a = 8'h11;
        tick(15);
        dout_a = 8'h00;
        tick(1);
        dout_a = 8'h22;
        tick(16); check_a("glitch_hold", E_CLKON);
        tick(1);  check_a("glitch_valid", E_VALID);
        tick(5);  check_a("glitch_ready", E_READY);
        en_a = 1'b0;
        tick(1);
        en_a = 1'b1;
        tick(2); check_a("mid_clkon", E_CLKON);
        tick(17); check_a("mid_valid", E_VALID);
        tick(2); check_a("mid_m1rst_2nd", E_M1RST);
        en_a = 1'b0;
        tick(1); check_a("mid_disable", E_IDLE);
        dout_a = 8'h00;
        en_a = 1'b1;
        tick(1); check_a("to_train", E_TRAIN);
        tick(1);
        tick(999); check_a("to_wait", E_CLKON);
        check("to_fail_pre", a_fail, 0);
        tick(1); check_a("to_holdoff", E_HOLDOFF);
        check("to_fail_set", a_fail, 1);
        tick(1023); check_a("holdoff_end", E_HOLDOFF);
        tick(1); check_a("retry_train", E_TRAIN);
        tick(1); check_a("retry_clkon", E_CLKON);
        check("fail_sticky", a_fail, 1);
        en_a = 1'b0;
        tick(1); check("fail_idle", a_fail, 1);
        en_a = 1'b1;
        tick(1); check("fail_clear", a_fail, 0);
        dout_a = 8'h5A;
        tick(1);
        tick(17);
        tick(5); check_a("pre_reset_ready", E_READY);
        #2 rstn = 1'b0;
        #1 check_a("async_reset", E_IDLE);
        tick(1);
        rstn = 1'b1;
        tick(3); check_a("rebring_train", E_TRAIN);
        tick(1);
        tick(17);
        tick(5); check_a("rebring_ready", E_READY);
        en_b = 1'b1;
        dout_b = 8'h7E;
        tick(2); check("race_clkon", b_st, 2);
        tick(16); check("race_pre", b_st, 2);
        tick(1); check("race_state", b_st, 3);
        check("race_valid", b_vld, 1);
        check("race_fail", b_fail, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
